// File: rtl/mem_access_ctrl.sv
// Purpose: sequences one CPU load/store into a synchronous RAM (SETUP, strobe, DONE).
// Latency: done in the cycle after edge N+1+WAIT_CYCLES (N = request edge); out-of-range after N+1.
// Backpressure: busy is high outside IDLE; requests arriving while busy are dropped, not queued.
module mem_access_ctrl #(
  parameter int WAIT_CYCLES = 1,
  parameter int MEM_WORDS   = 512
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic [31:0] rdata_out,
  output logic        busy,
  output logic        done,
  output logic        addr_err,
  output logic [31:0] ram_address,
  output logic [31:0] ram_data_in,
  output logic        ram_read,
  output logic        ram_write,
  input  logic [31:0] ram_data_out
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);
  localparam logic [3:0]  CNT_LOAD  = 4'(WAIT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [31:0] mar_q, mar_d;
  logic [31:0] mdr_q, mdr_d;
  logic        is_wr_q, is_wr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;

  // MAR/MDR feed the RAM directly, so address and write data stay put from
  // SETUP through DONE and keep their last values while idle.
  assign ram_address = mar_q;
  assign ram_data_in = mdr_q;
  assign rdata_out   = rdata_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign addr_err    = err_q;
  assign ram_read    = rd_q;
  assign ram_write   = wr_q;

  // Next-state logic; strobes, done and addr_err are computed one cycle ahead
  // so every output comes straight from a flop.
  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    is_wr_d = is_wr_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_read || req_write) begin
          mar_d   = addr_in;
          mdr_d   = wdata_in;
          is_wr_d = req_write;   // write wins when both are requested
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (mar_q < MEM_LIMIT) begin
          cnt_d   = CNT_LOAD;
          rd_d    = !is_wr_q;
          wr_d    = is_wr_q;
          state_d = S_ACCESS;
        end else begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          done_d  = 1'b1;
          if (!is_wr_q) begin
            rdata_d = ram_data_out;
          end
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          rd_d  = !is_wr_q;
          wr_d  = is_wr_q;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; clr aborts any access in flight.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      is_wr_q <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      is_wr_q <= is_wr_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: scoreboard of expected completions fed by a
// transaction-level model, checked by an independent monitor.
module tb_mem_access_ctrl;

  localparam int W  = 1;
  localparam int MW = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr, req_read, req_write, busy, done, addr_err, ram_read, ram_write;
  logic [31:0] addr_in, wdata_in, rdata_out, ram_address, ram_data_in, ram_data_out;

  logic        clr4, rr4, rw4, busy4, done4, err4, rd4, wr4;
  logic [31:0] a4, d4, rdata4, raddr4, rdin4, rdout4;

  mem_access_ctrl #(.WAIT_CYCLES(W), .MEM_WORDS(MW)) u_dut (
    .clk(clk), .clr(clr), .req_read(req_read), .req_write(req_write),
    .addr_in(addr_in), .wdata_in(wdata_in), .rdata_out(rdata_out),
    .busy(busy), .done(done), .addr_err(addr_err),
    .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_read(ram_read), .ram_write(ram_write), .ram_data_out(ram_data_out));

  mem_access_ctrl #(.WAIT_CYCLES(4), .MEM_WORDS(MW)) u_dut4 (
    .clk(clk), .clr(clr4), .req_read(rr4), .req_write(rw4),
    .addr_in(a4), .wdata_in(d4), .rdata_out(rdata4),
    .busy(busy4), .done(done4), .addr_err(err4),
    .ram_address(raddr4), .ram_data_in(rdin4),
    .ram_read(rd4), .ram_write(wr4), .ram_data_out(rdout4));

  assign rdout4 = raddr4 ^ 32'h5A5A_0000;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (i == 32'h47) ? 32'h94 : 32'(i * 7 + 3);
  endfunction

  // RAM seen by the DUT
  logic        load_en;
  logic [31:0] tb_ram [MW];
  assign ram_data_out = tb_ram[ram_address[8:0]];
  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < MW; i++) tb_ram[i] <= init_word(i);
    end else if (ram_write) begin
      tb_ram[ram_address[8:0]] <= ram_data_in;
    end
  end

  // Reference model state
  typedef struct {
    int          done_cyc;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    int          strobes;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] ref_mem [MW];
  logic [31:0] ref_rdata;
  int          free_at;

  // Drive one cycle of request inputs; the model decides whether the
  // controller is free to accept it on the coming edge.
  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int n;
    req_read = rd; req_write = wr; addr_in = a; wdata_in = d;
    n = cyc + 1;
    if ((rd || wr) && !clr && n >= free_at) begin
      e.addr = a; e.wdata = d; e.wr = wr;
      if (a < MW) begin
        e.err = 1'b0; e.done_cyc = n + 1 + W; e.strobes = W; free_at = n + W + 3;
        if (wr) ref_mem[a[8:0]] = d;
        else    ref_rdata = ref_mem[a[8:0]];
      end else begin
        e.err = 1'b1; e.done_cyc = n + 1; e.strobes = 0; free_at = n + 3;
      end
      e.rdata = ref_rdata;
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (cyc + 1 < free_at && k < 100) begin
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      k++;
    end
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    wait_idle();
    drive(rd, wr, a, d);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    wait_idle();
  endtask

  // Monitor: compares every completion against the scoreboard head
  int   strobe_cnt = 0;
  exp_t m;
  always @(negedge clk) begin
    if (!clr) begin
      check("strobe_excl", {31'b0, ram_read & ram_write}, 32'h0);
      check("err_without_done", {31'b0, addr_err & ~done}, 32'h0);
      if (ram_read || ram_write) strobe_cnt++;
      if (busy && sb.size() > 0) begin
        check("addr_stable", ram_address, sb[0].addr);
        check("wdata_stable", ram_data_in, sb[0].wdata);
        if (ram_read || ram_write) check("strobe_type", {31'b0, ram_write}, {31'b0, sb[0].wr});
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'h1, 32'h0);
        end else begin
          m = sb.pop_front();
          check("done_cycle", cyc, m.done_cyc);
          check("addr_err", {31'b0, addr_err}, {31'b0, m.err});
          check("rdata", rdata_out, m.rdata);
          check("strobe_cycles", strobe_cnt, m.strobes);
          check("busy_at_done", {31'b0, busy}, 32'h1);
        end
        strobe_cnt = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int first_done;
    int gap;
    clr = 1'b1; load_en = 1'b1;
    req_read = 1'b1; req_write = 1'b0; addr_in = 32'h5; wdata_in = 32'h77;
    clr4 = 1'b1; rr4 = 1'b0; rw4 = 1'b0; a4 = 32'h0; d4 = 32'h0;
    for (int i = 0; i < MW; i++) ref_mem[i] = init_word(i);
    ref_rdata = '0;
    repeat (3) @(negedge clk);
    // request held during clr must be ignored; everything cleared
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_rdata", rdata_out, 32'h0);
    check("rst_addr", ram_address, 32'h0);
    check("rst_wdata", ram_data_in, 32'h0);
    check("rst_strobes", {30'b0, ram_read, ram_write}, 32'h0);
    clr = 1'b0; load_en = 1'b0; clr4 = 1'b0; req_read = 1'b0;
    free_at = cyc + 1;

    // Directed scenarios
    issue(1'b1, 1'b0, 32'h47, 32'h0);
    check("read_0x47", rdata_out, 32'h94);
    issue(1'b0, 1'b1, 32'h8E, 32'h9);
    issue(1'b1, 1'b0, 32'h8E, 32'h0);
    check("readback_0x8E", rdata_out, 32'h9);
    issue(1'b1, 1'b1, 32'h27, 32'h37);
    check("both_ram_0x27", tb_ram[9'h27], 32'h37);
    check("both_rdata_kept", rdata_out, 32'h9);
    issue(1'b1, 1'b0, 32'h200, 32'h0);
    check("oob_rdata_kept", rdata_out, 32'h9);

    // Randomized traffic, including requests while busy
    for (int i = 0; i < 400; i++) begin
      logic rd, wr;
      logic [31:0] a;
      rd = ($urandom_range(0, 2) == 0);
      wr = ($urandom_range(0, 3) == 0);
      a  = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(512, 4096)) : 32'($urandom_range(0, 511));
      drive(rd, wr, a, $urandom);
    end
    wait_idle();

    // Read request held for 10 cycles
    seen = 0; first_done = 0; gap = 0;
    for (int i = 0; i <= 10; i++) begin
      if (i > 0 && done) begin
        if (seen == 0) first_done = cyc;
        else if (seen == 1) gap = cyc - first_done;
        seen++;
      end
      if (i < 10) drive(1'b1, 1'b0, 32'h10 + i, 32'h0);
      else        drive(1'b0, 1'b0, 32'h0, 32'h0);
    end
    check("held_done_count", seen, 2);
    check("held_done_gap", gap, 4);
    wait_idle();

    // WAIT_CYCLES=4 instance: complete a read, then abort the next one
    rr4 = 1'b1; a4 = 32'h5;
    @(negedge clk);
    rr4 = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (done4) seen = 1;
    end
    check("w4_done_seen", seen, 1);
    check("w4_rdata", rdata4, 32'h5 ^ 32'h5A5A_0000);
    @(negedge clk);
    rr4 = 1'b1; a4 = 32'h9;
    @(negedge clk);
    rr4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("w4_access2_strobe", {31'b0, rd4}, 32'h1);
    clr4 = 1'b1;
    @(negedge clk);
    clr4 = 1'b0;
    check("w4_abort_strobes", {30'b0, rd4, wr4}, 32'h0);
    check("w4_abort_busy", {31'b0, busy4}, 32'h0);
    check("w4_abort_rdata", rdata4, 32'h0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (done4) seen++;
      @(negedge clk);
    end
    check("w4_no_done", seen, 0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
